// File: rtl/card_dealer.sv
// Deals `count` cards from the deck into the lowest empty hand slots: DECK_DRAW, idle cycle, HAND_DOWN.
// Minimum 5 cycles per card. No backpressure; it owns the memory command port while busy.
module card_dealer #(
  parameter int          HAND_Y0   = 6,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [4:0]   count,
  input  logic         abort,
  input  logic [105:0] available_card,
  input  logic [6:0]   deck_card_cnt,
  input  logic [863:0] map,
  output logic         mem_en,
  output logic [3:0]   mem_msg_type,
  output logic [4:0]   mem_block_x,
  output logic [2:0]   mem_block_y,
  output logic [5:0]   mem_card,
  output logic         mem_move_dir,
  output logic [2:0]   mem_sel_len,
  output logic         busy,
  output logic         done,
  output logic [4:0]   dealt_cnt,
  output logic         err_deck_empty,
  output logic         err_hand_full
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SEEK   = 3'd1;
  localparam logic [2:0] S_DRAW   = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_PLACE  = 3'd4;
  localparam logic [2:0] S_SETTLE = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  logic [2:0]  state, state_nx;
  logic [15:0] lfsr;
  logic [4:0]  count_q;
  logic [5:0]  card_q;
  logic [4:0]  slot_x_q;
  logic [2:0]  slot_y_q;
  logic [6:0]  p_q, miss_q;
  logic        seek_first, abort_q;

  logic        slot_found;
  logic [4:0]  slot_x;
  logic [2:0]  slot_y;
  logic [6:0]  p_init, p_cur, p_next, miss_num;
  logic [5:0]  draw_card;
  logic        hit, set_deck_empty, set_hand_full;

  assign mem_move_dir = 1'b0;
  assign mem_sel_len  = 3'd0;

  // Scan from the top so the last match written is the lowest position.
  always_comb begin
    slot_found = 1'b0;
    slot_x     = 5'd0;
    slot_y     = 3'd0;
    for (int y = 7; y >= HAND_Y0; y--) begin
      for (int x = 17; x >= 0; x--) begin
        if (map[(x + 18*y)*6 +: 6] == 6'd54) begin
          slot_found = 1'b1;
          slot_x     = 5'(x);
          slot_y     = 3'(y);
        end
      end
    end
  end

  always_comb begin
    p_init    = (lfsr[6:0] >= 7'd106) ? lfsr[6:0] - 7'd106 : lfsr[6:0];
    p_cur     = seek_first ? p_init : p_q;
    p_next    = (p_cur == 7'd105) ? 7'd0 : p_cur + 7'd1;
    miss_num  = seek_first ? 7'd0 : miss_q;
    draw_card = (p_cur < 7'd54) ? 6'(p_cur) : 6'(p_cur - 7'd54);
    hit       = available_card[p_cur];
  end

  always_comb begin
    state_nx       = state;
    set_deck_empty = 1'b0;
    set_hand_full  = 1'b0;
    case (state)
      S_IDLE:   if (start) state_nx = (count == 5'd0) ? S_DONE : S_SEEK;
      S_SEEK: begin
        if (abort) begin
          state_nx = S_DONE;
        end else if (seek_first && deck_card_cnt == 7'd0) begin
          state_nx       = S_DONE;
          set_deck_empty = 1'b1;
        end else if (seek_first && !slot_found) begin
          state_nx      = S_DONE;
          set_hand_full = 1'b1;
        end else if (hit) begin
          state_nx = S_DRAW;
        end else if (miss_num == 7'd105) begin
          state_nx       = S_DONE;
          set_deck_empty = 1'b1;
        end
      end
      S_DRAW:   state_nx = S_WAIT;
      S_WAIT:   state_nx = S_PLACE;
      S_PLACE:  state_nx = S_SETTLE;
      S_SETTLE: state_nx = ((dealt_cnt + 5'd1) == count_q || abort_q || abort) ? S_DONE : S_SEEK;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      lfsr           <= LFSR_SEED;
      count_q        <= 5'd0;
      card_q         <= 6'd54;
      slot_x_q       <= 5'd0;
      slot_y_q       <= 3'd0;
      p_q            <= 7'd0;
      miss_q         <= 7'd0;
      seek_first     <= 1'b0;
      abort_q        <= 1'b0;
      mem_en         <= 1'b0;
      mem_msg_type   <= 4'd0;
      mem_block_x    <= 5'd0;
      mem_block_y    <= 3'd0;
      mem_card       <= 6'd54;
      busy           <= 1'b0;
      done           <= 1'b0;
      dealt_cnt      <= 5'd0;
      err_deck_empty <= 1'b0;
      err_hand_full  <= 1'b0;
    end else begin
      state      <= state_nx;
      lfsr       <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      busy       <= (state_nx != S_IDLE) && (state_nx != S_DONE);
      done       <= (state_nx == S_DONE);
      seek_first <= (state_nx == S_SEEK) && (state != S_SEEK);

      mem_en       <= (state_nx == S_DRAW) || (state_nx == S_PLACE);
      mem_msg_type <= (state_nx == S_DRAW) ? 4'd5 : (state_nx == S_PLACE) ? 4'd4 : 4'd0;
      mem_block_x  <= (state_nx == S_PLACE) ? slot_x_q : 5'd0;
      mem_block_y  <= (state_nx == S_PLACE) ? slot_y_q : 3'd0;
      mem_card     <= (state_nx == S_DRAW) ? draw_card : (state_nx == S_PLACE) ? card_q : 6'd54;

      if (state == S_IDLE && start) begin
        count_q        <= count;
        dealt_cnt      <= 5'd0;
        err_deck_empty <= 1'b0;
        err_hand_full  <= 1'b0;
        abort_q        <= 1'b0;
      end else begin
        if (set_deck_empty) err_deck_empty <= 1'b1;
        if (set_hand_full)  err_hand_full  <= 1'b1;
      end

      if (state == S_SEEK) begin
        if (hit) begin
          card_q   <= draw_card;
          slot_x_q <= slot_x;
          slot_y_q <= slot_y;
        end else begin
          p_q    <= p_next;
          miss_q <= miss_num + 7'd1;
        end
      end

      // Abort mid-card is deferred so the drawn card always lands in the hand.
      if (state == S_DRAW || state == S_WAIT || state == S_PLACE || state == S_SETTLE)
        abort_q <= abort_q | abort;
      if (state == S_SETTLE)
        dealt_cnt <= dealt_cnt + 5'd1;
    end
  end

endmodule

// File: tb/tb_card_dealer.sv
// Bench for card_dealer: memory model plus command scoreboard fed by a slot/card planner.
module tb_card_dealer;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [4:0]   count = 5'd0;
  logic         abort = 1'b0;
  logic [105:0] available_card;
  logic [6:0]   deck_card_cnt;
  logic [863:0] map;
  logic         mem_en, mem_move_dir, busy, done, err_deck_empty, err_hand_full;
  logic [3:0]   mem_msg_type;
  logic [4:0]   mem_block_x, dealt_cnt;
  logic [2:0]   mem_block_y, mem_sel_len;
  logic [5:0]   mem_card;

  card_dealer dut (
    .clk(clk), .rst(rst), .start(start), .count(count), .abort(abort),
    .available_card(available_card), .deck_card_cnt(deck_card_cnt), .map(map),
    .mem_en(mem_en), .mem_msg_type(mem_msg_type), .mem_block_x(mem_block_x),
    .mem_block_y(mem_block_y), .mem_card(mem_card), .mem_move_dir(mem_move_dir),
    .mem_sel_len(mem_sel_len), .busy(busy), .done(done), .dealt_cnt(dealt_cnt),
    .err_deck_empty(err_deck_empty), .err_hand_full(err_hand_full)
  );

  always #5 clk = ~clk;

  // card == 63 means "whatever the LFSR's first probe selects".
  typedef struct packed {
    logic [3:0] typ;
    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] card;
  } cmd_t;

  cmd_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  logic [15:0] lfsr_m, lfsr_last;
  always @(posedge clk or negedge rst)
    if (!rst) lfsr_m <= 16'hACE1;
    else      lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};

  cmd_t       e;
  logic [6:0] p;
  logic [5:0] exp_card, drawn_exp;
  logic       prev_en = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      if (mem_en) begin
        check("adjacent_strobe", prev_en, 0);
        if (exp_q.size() == 0) begin
          check("extra_strobe", mem_msg_type, 0);
        end else begin
          e = exp_q.pop_front();
          check("msg_type", mem_msg_type, e.typ);
          check("block_x", mem_block_x, e.x);
          check("block_y", mem_block_y, e.y);
          exp_card = e.card;
          if (e.card == 6'd63) begin
            if (e.typ == 4'd5) begin
              p = lfsr_last[6:0];
              if (p >= 7'd106) p = p - 7'd106;
              exp_card = (p < 7'd54) ? 6'(p) : 6'(p - 7'd54);
            end else begin
              exp_card = drawn_exp;
            end
          end
          if (e.typ == 4'd5) drawn_exp = exp_card;
          check("card", mem_card, exp_card);
        end
        if (mem_msg_type == 4'd5) deck_card_cnt = deck_card_cnt - 7'd1;
        else if (mem_msg_type == 4'd4) map[(int'(mem_block_x) + 18*int'(mem_block_y))*6 +: 6] = mem_card;
      end else if (busy) begin
        check("idle_card", mem_card, 54);
      end
      prev_en = mem_en;
    end else begin
      prev_en = 1'b0;
    end
    lfsr_last = lfsr_m;
  end

  task automatic plan(input int n, input logic [5:0] c);
    logic [863:0] m;
    int left;
    m = map;
    left = n;
    for (int y = 6; y < 8; y++)
      for (int x = 0; x < 18; x++)
        if (left > 0 && m[(x + 18*y)*6 +: 6] == 6'd54) begin
          exp_q.push_back(cmd_t'{4'd5, 5'd0, 3'd0, c});
          exp_q.push_back(cmd_t'{4'd4, 5'(x), 3'(y), c});
          m[(x + 18*y)*6 +: 6] = 6'd0;
          left--;
        end
  endtask

  task automatic run(input logic [4:0] n, input int exp_done, input bit do_abort, input bit do_restart);
    int  k;
    bit  aborted;
    aborted = 1'b0;
    @(negedge clk);
    start = 1'b1;
    count = n;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    while (!done && k < 400) begin
      abort = do_abort && mem_en && mem_msg_type == 4'd5 && !aborted;
      if (abort) aborted = 1'b1;
      start = do_restart && k == 3;
      if (start) count = 5'd7;
      @(negedge clk);
      k++;
    end
    abort = 1'b0;
    start = 1'b0;
    check("done_seen", done, 1);
    if (exp_done > 0) check("done_cycle", k, exp_done);
    check("busy_in_done", busy, 0);
    @(negedge clk);
    check("done_pulse", done, 0);
    check("sb_empty", exp_q.size(), 0);
  endtask

  task automatic clear_mem();
    available_card = '1;
    deck_card_cnt  = 7'd106;
    map            = {144{6'd54}};
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_en"}, mem_en, 0);
    check({tag, "_msg"}, mem_msg_type, 0);
    check({tag, "_x"}, mem_block_x, 0);
    check({tag, "_y"}, mem_block_y, 0);
    check({tag, "_card"}, mem_card, 54);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_dealt"}, dealt_cnt, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    clear_mem();
    #12;
    check_reset_outputs("reset");
    check("reset_err_deck", err_deck_empty, 0);
    check("reset_err_hand", err_hand_full, 0);
    @(negedge clk);
    rst = 1'b1;

    // Three cards from a full deck into an empty hand.
    plan(3, 6'd63);
    run(5'd3, 16, 1'b0, 1'b0);
    check("t1_dealt", dealt_cnt, 3);
    check("t1_deck", deck_card_cnt, 103);
    check("t1_err_deck", err_deck_empty, 0);

    // Only copy 60 (card 6) left; then the deck is empty.
    clear_mem();
    available_card = '0;
    available_card[60] = 1'b1;
    deck_card_cnt = 7'd1;
    plan(1, 6'd6);
    run(5'd1, 0, 1'b0, 1'b0);
    check("t2_dealt", dealt_cnt, 1);
    check("t2_deck", deck_card_cnt, 0);
    run(5'd1, 0, 1'b0, 1'b0);
    check("t2_err_deck", err_deck_empty, 1);
    check("t2_dealt_empty", dealt_cnt, 0);
    check("t2_err_hand", err_hand_full, 0);

    // Hand full except (17,7).
    clear_mem();
    for (int i = 108; i < 143; i++) map[i*6 +: 6] = 6'd0;
    plan(2, 6'd63);
    run(5'd2, 7, 1'b0, 1'b0);
    check("t3_err_hand", err_hand_full, 1);
    check("t3_dealt", dealt_cnt, 1);
    check("t3_err_deck", err_deck_empty, 0);

    // Abort during the first DRAW of a five-card deal.
    clear_mem();
    plan(1, 6'd63);
    run(5'd5, 6, 1'b1, 1'b0);
    check("t4_dealt", dealt_cnt, 1);

    // count = 0, then a start pulse while busy.
    run(5'd0, 1, 1'b0, 1'b0);
    check("t5_dealt_zero", dealt_cnt, 0);
    plan(2, 6'd63);
    run(5'd2, 11, 1'b0, 1'b1);
    check("t5_dealt", dealt_cnt, 2);

    // Reset between DRAW and PLACE.
    clear_mem();
    plan(1, 6'd63);
    @(negedge clk);
    start = 1'b1;
    count = 5'd1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!(mem_en && mem_msg_type == 4'd5) && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("t6_draw_seen", mem_en, 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs("t6_rst");
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    plan(1, 6'd63);
    run(5'd1, 6, 1'b0, 1'b0);
    check("t6_dealt", dealt_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/card_dealer.md
# card_dealer

Sequencer that deals cards from the shared deck into the local player's hand rows of the table/hand memory. On a `start` pulse it draws `count` cards one at a time. For each card it picks a pseudo-random still-available card, issues a DECK_DRAW command, then issues a HAND_DOWN command into the lowest empty hand slot. It sits between GameControl and the memory's `ctrl_*` command port and owns that port while `busy` is high.

## Interface
- `HAND_Y0`, 6: first map row belonging to the hand; hand occupies rows `HAND_Y0`..7.
- `LFSR_SEED`, 16'hACE1: LFSR reset value; must be non-zero.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `count` in 5: number of cards to deal; latched with `start`.
- `abort` in 1: stop after the card currently in flight.
- `available_card` in 106: memory's availability vector; bit i set = copy i still in deck.
- `deck_card_cnt` in 7: memory's deck count.
- `map` in 864: memory's map, 144 six-bit slots, position = x + 18*y; value 54 = empty.
- `mem_en` out 1: one-cycle command strobe to `ctrl_en`.
- `mem_msg_type` out 4: 5 = DECK_DRAW, 4 = HAND_DOWN.
- `mem_block_x` out 5, `mem_block_y` out 3: target slot.
- `mem_card` out 6: card value 0–53.
- `mem_move_dir` out 1, `mem_sel_len` out 3: tied 0.
- `busy` out 1: high from the cycle after an accepted `start` until DONE. Upstream holds `transmit`=1 while high.
- `done` out 1: one-cycle pulse on completion.
- `dealt_cnt` out 5: cards fully placed in the current/last run.
- `err_deck_empty` out 1, `err_hand_full` out 1: sticky until the next accepted `start`.

## Operation
- States: IDLE, SEEK, DRAW, WAIT, PLACE, SETTLE, DONE.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle from reset.
- IDLE:
  - With `start` asserted: latch `count`, clear `dealt_cnt` and error flags.
  - If `count`==0, go to DONE; otherwise go to SEEK.
- SEEK entry (first cycle):
  - If `deck_card_cnt`==0, set `err_deck_empty` and go to DONE.
  - Compute slot = lowest position in rows `HAND_Y0`..7 whose map value is 54. If none, set `err_hand_full` and go to DONE.
  - Probe index p = `lfsr[6:0]`, minus 106 if ≥106.
- SEEK probing, one probe per cycle:
  - If `available_card[p]`, latch card = (p<54 ? p : p−54) and latch the slot x/y, then go to DRAW.
  - Otherwise p = (p==105 ? 0 : p+1).
  - After 106 consecutive misses, set `err_deck_empty` and go to DONE.
- `abort` seen in SEEK: go to DONE. In DRAW/WAIT/PLACE/SETTLE it is latched and honoured at SETTLE exit, so the card is never left half-moved.
- DRAW: `mem_en`=1, msg 5, `mem_card`=card, x/y=0. Then WAIT.
- WAIT: one idle cycle so the memory registers the draw and clears its pending remove position. Then PLACE.
- PLACE: `mem_en`=1, msg 4, latched x/y and card. Then SETTLE.
- SETTLE:
  - Increment `dealt_cnt`; the map update is now visible.
  - Go to DONE if `dealt_cnt`+1==count or abort is latched; otherwise go to SEEK.
- DONE: `done`=1 for one cycle, `busy`=0, then IDLE.
- `start` while busy is ignored.

## Timing
- Reset values: state IDLE, LFSR=`LFSR_SEED`, `mem_en`=0, `mem_msg_type`=0, x/y=0, `mem_card`=54, `busy`=0, `done`=0, `dealt_cnt`=0, both error flags 0.
- All outputs are registered. Command fields are valid only in the `mem_en` cycle; `mem_card` returns to 54 otherwise.
- Per card: SEEK (1 cycle on first-probe hit, ≤106 cycles) + DRAW + WAIT + PLACE + SETTLE = min 5 cycles.
- `count`=N with no misses: `done` pulses at cycle 1+5N after `start` (count=0: `done` 1 cycle after `start`).
- Exactly two `mem_en` pulses per dealt card, never adjacent.
- Reset mid-deal: immediate return to IDLE. No further strobes; the memory's contents are not repaired.

## Test plan
- Reset, then `start`, `count`=3, full deck, empty hand → six strobes ordered 5,4,5,4,5,4. Slots (0,6),(1,6),(2,6); `dealt_cnt`=3; `done` at cycle 16; `deck_card_cnt` 106→103.
- `available_card` with only bit 60 set, `deck_card_cnt`=1, `count`=1 → DRAW card 6, PLACE card 6; second `start` with `count`=1 → `err_deck_empty`=1, `dealt_cnt`=0, no strobe.
- Hand rows 6–7 fully occupied except (17,7), `count`=2 → first card to (17,7); then `err_hand_full`=1, `dealt_cnt`=1.
- `abort` during DRAW of card 1 of `count`=5 → that HAND_DOWN still issued, `dealt_cnt`=1, `done` pulses, no further strobes.
- `start` with `count`=0 → `done` next cycle, no `mem_en`. `start` pulsed while busy → ignored, run unchanged.
- Async `rst` low between DRAW and PLACE → outputs at reset values that cycle; next `start` operates normally.
